// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache miss handler: state
// encoding, default widths and small state-classification helpers.
package cache_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 16;

  // 4-bit state encoding, consumed directly by mem_signals
  localparam logic [3:0] S_IDLE  = 4'b0000;
  localparam logic [3:0] S_WB0   = 4'b0001;
  localparam logic [3:0] S_WB1   = 4'b0010;
  localparam logic [3:0] S_WB2   = 4'b0011;
  localparam logic [3:0] S_WB3   = 4'b0100;
  localparam logic [3:0] S_RD0   = 4'b0101;
  localparam logic [3:0] S_RD1   = 4'b0110;
  localparam logic [3:0] S_RD2   = 4'b0111;
  localparam logic [3:0] S_RD3   = 4'b1000;
  localparam logic [3:0] S_FILL2 = 4'b1001;
  localparam logic [3:0] S_FILL3 = 4'b1010;
  localparam logic [3:0] S_RETRY = 4'b1011;
  localparam logic [3:0] S_DONE  = 4'b1100;

  // True for the write-back and fill-request states, which talk to the
  // four-bank memory and therefore honour mem_stall.
  function automatic logic is_mem_state(input logic [3:0] st);
    return (st >= S_WB0) && (st <= S_RD3);
  endfunction

  // True for any encoding the FSM can legitimately reach.
  function automatic logic is_legal_state(input logic [3:0] st);
    return st <= S_DONE;
  endfunction

endpackage

// File: rtl/cache_ctrl_fsm_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear. Sticks at
// all-ones so a long run never wraps back to a small value.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_r;

  assign count = count_r;

  // Count up on inc, holding once the maximum value is reached
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Miss-handling state machine for the direct-mapped cache. Latches the CPU
// request on accept, walks write-back / fill / retry, and counts accesses
// and misses. All outputs come straight from flops.
module cache_ctrl_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              hit,
  input  logic              valid,
  input  logic              dirty,
  input  logic              mem_stall,
  output logic [3:0]        state,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_data,
  output logic              req_wr,
  output logic              busy,
  output logic              err,
  output logic [CNT_W-1:0]  acc_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  logic [3:0]        state_r;
  logic [ADDR_W-1:0] req_addr_r;
  logic [DATA_W-1:0] req_data_r;
  logic              req_wr_r;
  logic              busy_r;
  logic              err_r;

  logic [3:0]        next_state_s;
  logic              accept_s;
  logic              miss_s;
  logic              err_set_s;

  assign state    = state_r;
  assign req_addr = req_addr_r;
  assign req_data = req_data_r;
  assign req_wr   = req_wr_r;
  assign busy     = busy_r;
  assign err      = err_r;

  // Next-state decode plus accept/miss/error strobes for this cycle
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    miss_s       = 1'b0;
    err_set_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (rd && wr) begin
          err_set_s    = 1'b1;
          next_state_s = S_IDLE;
        end else if (rd ^ wr) begin
          accept_s = 1'b1;
          if (hit && valid) begin
            next_state_s = S_IDLE;
          end else if (valid && dirty) begin
            miss_s       = 1'b1;
            next_state_s = S_WB0;
          end else begin
            miss_s       = 1'b1;
            next_state_s = S_RD0;
          end
        end else begin
          next_state_s = S_IDLE;
        end
      end
      // WB3 -> RD0 and RD3 -> FILL2 are both plain increments of the encoding
      S_WB0, S_WB1, S_WB2, S_WB3, S_RD0, S_RD1, S_RD2, S_RD3: begin
        if (mem_stall) begin
          next_state_s = state_r;
        end else begin
          next_state_s = state_r + 4'd1;
        end
      end
      S_FILL2: next_state_s = S_FILL3;
      S_FILL3: next_state_s = S_RETRY;
      S_RETRY: next_state_s = S_DONE;
      S_DONE:  next_state_s = S_IDLE;
      default: begin
        next_state_s = S_IDLE;
        err_set_s    = 1'b1;
      end
    endcase
  end

  // State register, request latch, busy and sticky error flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      req_addr_r <= {ADDR_W{1'b0}};
      req_data_r <= {DATA_W{1'b0}};
      req_wr_r   <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != S_IDLE);
      err_r   <= err_r | err_set_s;
      if (accept_s) begin
        req_addr_r <= addr;
        req_data_r <= data_in;
        req_wr_r   <= wr;
      end else begin
        req_addr_r <= req_addr_r;
        req_data_r <= req_data_r;
        req_wr_r   <= req_wr_r;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_acc_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .inc   (accept_s),
    .count (acc_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .inc   (miss_s),
    .count (miss_cnt)
  );

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed bench for cache_ctrl_fsm: reset, hit, clean miss, stalled dirty
// miss, rd&wr error, mid-miss reset and illegal-state recovery.
module tb_cache_ctrl_fsm;

  logic        clk;
  logic        rst_n;
  logic        rd;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        hit;
  logic        valid;
  logic        dirty;
  logic        mem_stall;
  logic [3:0]  state;
  logic [15:0] req_addr;
  logic [15:0] req_data;
  logic        req_wr;
  logic        busy;
  logic        err;
  logic [15:0] acc_cnt;
  logic [15:0] miss_cnt;

  int checks;
  int errors;

  cache_ctrl_fsm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd        (rd),
    .wr        (wr),
    .addr      (addr),
    .data_in   (data_in),
    .hit       (hit),
    .valid     (valid),
    .dirty     (dirty),
    .mem_stall (mem_stall),
    .state     (state),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_wr    (req_wr),
    .busy      (busy),
    .err       (err),
    .acc_cnt   (acc_cnt),
    .miss_cnt  (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] clean_seq [8];
    int n;
    checks = 0;
    errors = 0;
    clean_seq = '{4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b0000};

    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = 16'h0000; data_in = 16'h0000;
    hit = 1'b0; valid = 1'b0; dirty = 1'b0; mem_stall = 1'b0;

    // 1. reset
    #12;
    chk("rst_state", {28'd0, state}, 32'h0);
    chk("rst_err", {31'd0, err}, 32'h0);
    chk("rst_acc", {16'd0, acc_cnt}, 32'h0);
    chk("rst_miss", {16'd0, miss_cnt}, 32'h0);
    chk("rst_addr", {16'd0, req_addr}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2. read hit
    @(negedge clk);
    rd = 1'b1; addr = 16'h1234; hit = 1'b1; valid = 1'b1;
    step();
    rd = 1'b0; hit = 1'b0;
    chk("hit_state", {28'd0, state}, 32'h0);
    chk("hit_addr", {16'd0, req_addr}, 32'h1234);
    chk("hit_acc", {16'd0, acc_cnt}, 32'd1);
    chk("hit_miss", {16'd0, miss_cnt}, 32'd0);
    chk("hit_busy", {31'd0, busy}, 32'd0);

    // 3. clean write miss
    @(negedge clk);
    wr = 1'b1; addr = 16'h00A0; data_in = 16'hBEEF; valid = 1'b1; dirty = 1'b0;
    step();
    wr = 1'b0;
    chk("clean_rd0", {28'd0, state}, 32'h5);
    chk("clean_busy", {31'd0, busy}, 32'd1);
    chk("clean_wr", {31'd0, req_wr}, 32'd1);
    chk("clean_acc", {16'd0, acc_cnt}, 32'd2);
    chk("clean_miss", {16'd0, miss_cnt}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      addr = ~addr;
      step();
      chk($sformatf("clean_seq%0d", i), {28'd0, state}, {28'd0, clean_seq[i]});
    end
    chk("clean_hold_addr", {16'd0, req_addr}, 32'h00A0);
    chk("clean_hold_data", {16'd0, req_data}, 32'hBEEF);
    chk("clean_idle_busy", {31'd0, busy}, 32'd0);

    // 4. dirty read miss with 2 stall cycles in WB1
    @(negedge clk);
    rd = 1'b1; addr = 16'h0F00; valid = 1'b1; dirty = 1'b1;
    step();
    rd = 1'b0; dirty = 1'b0;
    chk("dirty_wb0", {28'd0, state}, 32'h1);
    step();
    chk("dirty_wb1", {28'd0, state}, 32'h2);
    mem_stall = 1'b1;
    step();
    chk("stall_hold1", {28'd0, state}, 32'h2);
    step();
    chk("stall_hold2", {28'd0, state}, 32'h2);
    mem_stall = 1'b0;
    n = 3;
    while (state != 4'b0000 && n < 40) begin
      step();
      n++;
    end
    chk("dirty_latency", n, 32'd14);
    chk("dirty_acc", {16'd0, acc_cnt}, 32'd3);
    chk("dirty_miss", {16'd0, miss_cnt}, 32'd2);
    chk("dirty_addr", {16'd0, req_addr}, 32'h0F00);
    chk("dirty_wr", {31'd0, req_wr}, 32'd0);

    // 5. rd and wr together
    @(negedge clk);
    rd = 1'b1; wr = 1'b1; addr = 16'h5555;
    step();
    rd = 1'b0; wr = 1'b0;
    chk("both_err", {31'd0, err}, 32'd1);
    chk("both_state", {28'd0, state}, 32'h0);
    chk("both_acc", {16'd0, acc_cnt}, 32'd3);
    chk("both_addr", {16'd0, req_addr}, 32'h0F00);
    step();
    chk("err_sticky", {31'd0, err}, 32'd1);

    // 6a. reset mid-miss
    @(negedge clk);
    wr = 1'b1; addr = 16'h0055; valid = 1'b1; dirty = 1'b0;
    step();
    wr = 1'b0;
    step();
    chk("pre_rst_state", {28'd0, state}, 32'h6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_state", {28'd0, state}, 32'h0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    chk("midrst_acc", {16'd0, acc_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_state", {28'd0, state}, 32'h0);

    // 6b. illegal state recovery
    @(negedge clk);
    force dut.state_r = 4'b1110;
    #1;
    release dut.state_r;
    chk("illegal_forced", {28'd0, state}, 32'hE);
    chk("illegal_err_pre", {31'd0, err}, 32'd0);
    step();
    chk("illegal_state", {28'd0, state}, 32'h0);
    chk("illegal_err", {31'd0, err}, 32'd1);
    step();
    chk("illegal_err_sticky", {31'd0, err}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
